// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the unified-memory initiator.
// Optional alignment check is enabled with MEM_MASTER_ALIGN_CHECK_EN.
package mem_master_pkg;

  localparam int AW_D     = 16;
  localparam int DW_D     = 16;
  localparam int STRIDE_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } state_t;

endpackage

// File: rtl/mem_master.sv
// Sequences 16/32-bit core requests into one or two memory beats.
// Define MEM_MASTER_ALIGN_CHECK_EN to reject misaligned requests.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int AW     = AW_D,
  parameter int DW     = DW_D,
  parameter int STRIDE = STRIDE_D
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic            req_wide,
  input  logic [AW-1:0]   req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [2*DW-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [AW-1:0]   mem_a,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);

  state_t state;
  state_t state_n;

  logic          wr_q;
  logic          wide_q;
  logic [DW-1:0] whi_q;
  logic          misal;

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  assign misal = (req_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req_valid) state_n = misal ? RESP : BEAT0;
      BEAT0:   state_n = wide_q ? BEAT1 : RESP;
      BEAT1:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      wide_q    <= 1'b0;
      whi_q     <= '0;
      rsp_rdata <= '0;
      mem_a     <= '0;
      mem_we    <= 1'b0;
      mem_wd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q   <= req_write;
            wide_q <= req_wide;
            whi_q  <= req_wdata[2*DW-1:DW];
            if (!misal) begin
              mem_a  <= req_addr;
              mem_we <= req_write;
              mem_wd <= req_wdata[DW-1:0];
            end
          end
        end
        BEAT0: begin
          if (!wr_q) begin
            rsp_rdata[DW-1:0] <= mem_rd;
            if (!wide_q) rsp_rdata[2*DW-1:DW] <= '0;
          end
          if (wide_q) begin
            mem_a  <= mem_a + AW'(STRIDE);
            mem_wd <= whi_q;
          end else begin
            mem_we <= 1'b0;
          end
        end
        BEAT1: begin
          if (!wr_q) rsp_rdata[2*DW-1:DW] <= mem_rd;
          mem_we <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  logic err_q;

  // Error flag lives from accept until the response cycle ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      err_q <= misal;
    end else if (state == RESP) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q & rsp_valid;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a word-indexed memory model.
// Expectations follow MEM_MASTER_ALIGN_CHECK_EN when defined.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [15:0] mem_wd;
  logic [15:0] mem_rd;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [0:16383];
  int          we_cnt = 0;
  logic [15:0] we_a0;
  logic [15:0] we_a1;

  mem_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_a     (mem_a),
    .mem_we    (mem_we),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[15:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[15:2]] <= mem_wd;
      if (we_cnt == 0) we_a0 = mem_a;
      if (we_cnt == 1) we_a1 = mem_a;
      we_cnt = we_cnt + 1;
    end
  end

  // mem_we must be low whenever the FSM is in IDLE or RESP.
  always @(negedge clk) begin
    if (!reset) begin
      total = total + 1;
      if (mem_we && (req_ready || rsp_valid)) begin
        bad = bad + 1;
        $display("FAIL we_outside_beat got=1 exp=0 t=%0t", $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic        wide;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vt [10];

  task automatic do_req(input vec_t v, input int idx);
    int  lat;
    bit  got;
    @(negedge clk);
    we_cnt    = 0;
    req_valid = 1'b1;
    req_write = v.w;
    req_wide  = v.wide;
    req_addr  = v.addr;
    req_wdata = v.wd;
    chk($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'hDEAD;
    req_wdata = 32'hBAD0BAD0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat = lat + 1;
      if (rsp_valid) got = 1'b1;
    end
    chk($sformatf("v%0d_rsp_seen", idx), {31'b0, got}, 32'd1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rd);
    chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_we_cnt", idx), we_cnt, v.exp_we);
    if (v.exp_we > 0)
      chk($sformatf("v%0d_we_a0", idx), {16'b0, we_a0}, {16'b0, v.addr});
    if (v.exp_we > 1)
      chk($sformatf("v%0d_we_a1", idx), {16'b0, we_a1},
          {16'b0, v.addr + 16'd4});
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse", idx), {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int acc;
    int np;
    int last_c;
    int rv_cnt;

    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;

    vt[0] = '{1'b1, 1'b0, 16'h0008, 32'h0000_1234, 32'h0000_0000, 1'b0, 2, 1};
    vt[1] = '{1'b0, 1'b0, 16'h0008, 32'h0,         32'h0000_1234, 1'b0, 2, 0};
    vt[2] = '{1'b1, 1'b1, 16'h0010, 32'hAABB_CCDD, 32'h0000_1234, 1'b0, 3, 2};
    vt[3] = '{1'b0, 1'b1, 16'h0010, 32'h0,         32'hAABB_CCDD, 1'b0, 3, 0};
    vt[4] = '{1'b1, 1'b0, 16'hFFFC, 32'h0000_5555, 32'hAABB_CCDD, 1'b0, 2, 1};
    vt[5] = '{1'b1, 1'b0, 16'h0000, 32'h0000_6666, 32'hAABB_CCDD, 1'b0, 2, 1};
    vt[6] = '{1'b0, 1'b1, 16'hFFFC, 32'h0,         32'h6666_5555, 1'b0, 3, 0};
    vt[7] = '{1'b0, 1'b0, 16'h0014, 32'h0,         32'h0000_AABB, 1'b0, 2, 0};
    vt[8] = '{1'b0, 1'b0, 16'h0010, 32'h0,         32'h0000_CCDD, 1'b0, 2, 0};
`ifdef MEM_MASTER_ALIGN_CHECK_EN
    vt[9] = '{1'b1, 1'b0, 16'h0006, 32'h0000_7777, 32'h0000_CCDD, 1'b1, 1, 0};
`else
    vt[9] = '{1'b1, 1'b0, 16'h0006, 32'h0000_7777, 32'h0000_CCDD, 1'b0, 2, 1};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_mem_a", {16'b0, mem_a}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_wd", {16'b0, mem_wd}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_req(vt[i], i);

`ifdef MEM_MASTER_ALIGN_CHECK_EN
    chk("align_mem1", {16'b0, mem[1]}, 32'h0000);
    do_req('{1'b0, 1'b0, 16'h0004, 32'h0, 32'h0000_0000, 1'b0, 2, 0}, 10);
`else
    chk("align_mem1", {16'b0, mem[1]}, 32'h7777);
    do_req('{1'b0, 1'b0, 16'h0004, 32'h0, 32'h0000_7777, 1'b0, 2, 0}, 10);
`endif

    // Back-to-back narrow reads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 16'h0008;
    acc = 0;
    np = 0;
    last_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) begin
        chk("b2b_rdata", rsp_rdata, 32'h0000_1234);
        if (last_c >= 0) chk("b2b_gap", c - last_c, 3);
        last_c = c;
        np = np + 1;
      end
      if (req_ready && rsp_valid)
        chk("b2b_ready_in_resp", 32'd1, 32'd0);
      if (req_ready && req_valid) acc = acc + 1;
      @(posedge clk);
      #1;
      if (acc == 5) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", acc, 5);
    chk("b2b_pulses", np, 5);

    // Reset asserted during BEAT0 of a wide write.
    @(negedge clk);
    we_cnt    = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_we_beat0", {31'b0, mem_we}, 32'd1);
    chk("mid_a_beat0", {16'b0, mem_a}, 32'h0020);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_we_async", {31'b0, mem_we}, 32'd0);
    chk("mid_mem_a", {16'b0, mem_a}, 32'd0);
    chk("mid_mem_wd", {16'b0, mem_wd}, 32'd0);
    chk("mid_rdata", rsp_rdata, 32'd0);
    chk("mid_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) rv_cnt = rv_cnt + 1;
    end
    chk("mid_no_rsp", rv_cnt, 0);
    chk("mid_we_cnt", we_cnt, 0);
    chk("mid_mem8", {16'b0, mem[8]}, 32'h0000);
    chk("mid_mem9", {16'b0, mem[9]}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
